fifo_1clk: RTL and testbench
============================

Name: fifo_1clk

Overview:
Single-clock synchronous FIFO; the parametrised successor to the dual-clock FIFO for same-domain buffering.
- Adds fill count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode.
- Adds optional sticky overflow/underflow error flags.
- No pointer synchronisers: both ports share one clock.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 256, storage words; power of two, >=4.
- FWFT, 0, read mode: 0 = standard (registered read-on-request), 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this; range 1..DEPTH.
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this; range 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_sync  input  1  synchronous active-high reset.
- din  input  WIDTH  write data.
- wr_en  input  1  write request.
- full  output  1  no space; writes ignored.
- almost_full  output  1  count >= AFULL_THRESH.
- rd_en  input  1  read request (FWFT: pop/acknowledge).
- dout  output  WIDTH  read data.
- empty  output  1  no readable word.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  $clog2(DEPTH)+1  words held, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
Reset (rst_sync high at a clk edge, any time incl. mid-burst):
- Pointers and count reset to 0; output register cleared.
- Outputs after reset: dout=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0.
- Storage array is not cleared.
- rst_sync has priority over wr_en/rd_en in the same cycle.

Write:
- Accepted iff wr_en && !full.
- din stored at wr_ptr; wr_ptr advances mod DEPTH.
- full is not relieved by a same-cycle read: a write while full is always dropped.

Pointers:
- ADDR_WIDTH+1 bits with an extra wrap bit.
- full = low bits equal && wrap bits differ.
- Status is derived from registered pointers/count, so it updates on the edge after the accepting event.

Standard mode (FWFT=0):
- Read accepted iff rd_en && !empty.
- dout updates on that edge (data visible one cycle after the rd_en cycle); dout holds its value otherwise.
- empty = (count == 0).
- A write at edge N makes empty=0 after edge N.

FWFT mode (FWFT=1):
- An output register holds the head word; dout is valid whenever empty=0.
- rd_en && !empty consumes the head word; the next word (if any) appears after the same edge with no bubble.
- A write into a fully empty FIFO at edge N gives empty=0 and dout=word after edge N+1 (one extra cycle of latency).
- count includes the word held in the output register.
- rd_en while empty is ignored.

Simultaneous events:
- Accepted write + accepted read: count unchanged.
- Both requested while empty: write accepted, read ignored; count goes 0->1.
- Both requested while full: read accepted, write dropped; count goes DEPTH->DEPTH-1.

Status flags:
- almost_full and almost_empty are combinational compares on the count register.

Wrap-around:
- Pointers wrap silently past DEPTH-1.
- Data order is preserved across any number of wraps.

Optional Feature:
Macro FIFO_1CLK_ERR_FLAGS_EN.
- Defined: overflow sets on the edge after any cycle with wr_en && full. underflow sets on the edge after any cycle with rd_en && empty. Both stay set until rst_sync.
- Not defined: overflow and underflow are tied 0 and no flag registers are built. Ports remain present.

Test Plan:
- Reset then idle -> empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0.
- DEPTH=16, FWFT=0: write 0x00..0x0F back-to-back -> full=1 after the 16th edge, count=16, almost_full=1 from count=12. Then read 16 -> dout=0x00..0x0F in order, one cycle after each rd_en; empty=1 at the end.
- DEPTH=16, FWFT=1: single write 0xA5 into an empty FIFO -> empty=0 and dout=0xA5 two edges after the write. Assert rd_en one cycle -> empty=1, count=0.
- Full FIFO with wr_en=rd_en=1 for one cycle -> count 16->15, incoming word dropped. With FIFO_1CLK_ERR_FLAGS_EN defined -> overflow=1 and stays 1.
- Continuous 1 write + 1 read per cycle for 100 cycles (pointer wraps ~6 times) -> count stays constant, output sequence equals input sequence.
- rst_sync pulse mid-burst with count=9 -> next cycle count=0, empty=1, overflow=underflow=0. A write after release reads back correctly.

Source files
------------

// File: rtl/fifo_1clk.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_1clk
//  Brief    : Single-clock synchronous FIFO with fill count, programmable
//             almost-full / almost-empty thresholds and a selectable
//             standard or first-word-fall-through (FWFT) read mode.
//  Options  : FIFO_1CLK_ERR_FLAGS_EN - when defined, builds sticky
//             overflow/underflow flag registers; otherwise both ports are
//             tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_1clk #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 256,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst_sync,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int                    c_addr_width = $clog2(DEPTH);
    localparam logic [c_addr_width:0] c_ptr_one    = {{c_addr_width{1'b0}}, 1'b1};
    localparam logic [c_addr_width:0] c_depth      = (c_addr_width + 1)'(DEPTH);
    localparam logic [c_addr_width:0] c_afull_thr  = (c_addr_width + 1)'(AFULL_THRESH);
    localparam logic [c_addr_width:0] c_aempty_thr = (c_addr_width + 1)'(AEMPTY_THRESH);

    // Storage array; intentionally has no reset.
    logic [WIDTH-1:0]        r_mem [DEPTH];

    // Pointers carry one extra wrap bit above the address bits.
    logic [c_addr_width:0]   r_wr_ptr;
    logic [c_addr_width:0]   r_rd_ptr;
    logic [c_addr_width:0]   r_count;
    logic [WIDTH-1:0]        r_dout;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_acc;   // write accepted this cycle
    logic                    w_rd_acc;   // user read accepted this cycle
    logic                    w_pop;      // a word leaves storage this cycle

    // A write while full is always dropped, even with a same-cycle read.
    assign w_wr_acc = wr_en && !w_full;

    // Write port into storage.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[c_addr_width-1:0]] <= din;
        end
    end

    // Write pointer advances on every accepted write, wrapping silently.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
    end

    // Read pointer advances whenever a word is taken out of storage.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Fill count tracks user-visible writes and reads; in FWFT mode it
    // includes the word parked in the output register.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ptr_one;
                2'b01:   r_count <= r_count - c_ptr_one;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            // Standard mode: status straight from the pointers and count.
            assign w_empty  = (r_count == '0);
            assign w_full   = (r_wr_ptr[c_addr_width-1:0] == r_rd_ptr[c_addr_width-1:0]) &&
                              (r_wr_ptr[c_addr_width] != r_rd_ptr[c_addr_width]);
            assign w_rd_acc = rd_en && !w_empty;
            assign w_pop    = w_rd_acc;

            // Registered read: data appears the edge after the request.
            always_ff @(posedge clk) begin
                if (rst_sync) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr[c_addr_width-1:0]];
                end
            end
        end else begin : g_fwft
            logic r_out_valid;
            logic w_mem_nonempty;

            // Storage alone holds (count - r_out_valid) words; the output
            // register adds one more slot, so fullness is taken from the
            // overall count rather than the storage pointers.
            assign w_mem_nonempty = (r_wr_ptr != r_rd_ptr);
            assign w_empty        = !r_out_valid;
            assign w_full         = (r_count == c_depth);
            assign w_rd_acc       = rd_en && r_out_valid;
            assign w_pop          = w_mem_nonempty && (!r_out_valid || w_rd_acc);

            // Head-word register: refilled from storage when it is free or
            // being consumed, so back-to-back reads see no bubble.
            always_ff @(posedge clk) begin
                if (rst_sync) begin
                    r_out_valid <= 1'b0;
                    r_dout      <= '0;
                end else if (w_pop) begin
                    r_out_valid <= 1'b1;
                    r_dout      <= r_mem[r_rd_ptr[c_addr_width-1:0]];
                end else if (w_rd_acc) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef FIFO_1CLK_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign dout         = r_dout;
    assign count        = r_count;
    assign almost_full  = (r_count >= c_afull_thr);
    assign almost_empty = (r_count <= c_aempty_thr);

endmodule
`default_nettype wire

// File: tb/tb_fifo_1clk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_1clk
//  Brief    : Self-checking bench for fifo_1clk; runs a standard-mode and an
//             FWFT-mode instance side by side against queue-based models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_1clk;

    localparam int c_w  = 8;
    localparam int c_d  = 16;
    localparam int c_af = 12;
    localparam int c_ae = 4;

`ifdef FIFO_1CLK_ERR_FLAGS_EN
    localparam bit c_err_en = 1'b1;
`else
    localparam bit c_err_en = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_sync;
    logic [c_w-1:0] din;
    logic           wr_en;
    logic           rd_en;

    logic           s_full, s_afull, s_empty, s_aempty, s_ov, s_un;
    logic [c_w-1:0] s_dout;
    logic [4:0]     s_count;
    logic           f_full, f_afull, f_empty, f_aempty, f_ov, f_un;
    logic [c_w-1:0] f_dout;
    logic [4:0]     f_count;

    fifo_1clk #(.WIDTH(c_w), .DEPTH(c_d), .FWFT(0),
                .AFULL_THRESH(c_af), .AEMPTY_THRESH(c_ae)) u_std (
        .clk(clk), .rst_sync(rst_sync), .din(din), .wr_en(wr_en),
        .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .dout(s_dout),
        .empty(s_empty), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ov), .underflow(s_un)
    );

    fifo_1clk #(.WIDTH(c_w), .DEPTH(c_d), .FWFT(1),
                .AFULL_THRESH(c_af), .AEMPTY_THRESH(c_ae)) u_fwft (
        .clk(clk), .rst_sync(rst_sync), .din(din), .wr_en(wr_en),
        .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .dout(f_dout),
        .empty(f_empty), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ov), .underflow(f_un)
    );

    always #5 clk = ~clk;

    // Reference state. Standard mode: a plain queue plus the last read word.
    // FWFT mode: each word remembers the edge it was written on; the head
    // becomes visible one edge after its write, and never before the edge on
    // which its predecessor was consumed.
    typedef struct {
        logic [c_w-1:0] data;
        int             wedge;
    } word_t;

    logic [c_w-1:0] sq[$];
    logic [c_w-1:0] s_exp_dout;
    word_t          fq[$];
    int             edge_n;
    int             last_pop;
    bit             m_s_ov, m_s_un, m_f_ov, m_f_un;

    int             n_checks = 0;
    int             n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic bit f_visible();
        int t;
        if (fq.size() == 0) return 1'b0;
        t = fq[0].wedge + 1;
        if (last_pop > t) t = last_pop;
        return (t <= edge_n);
    endfunction

    task automatic check_all();
        int sn;
        int fn;
        sn = sq.size();
        fn = fq.size();
        check_eq("std_count",  32'(s_count),  32'(sn));
        check_eq("std_empty",  32'(s_empty),  32'(sn == 0));
        check_eq("std_full",   32'(s_full),   32'(sn == c_d));
        check_eq("std_afull",  32'(s_afull),  32'(sn >= c_af));
        check_eq("std_aempty", 32'(s_aempty), 32'(sn <= c_ae));
        check_eq("std_dout",   32'(s_dout),   32'(s_exp_dout));
        check_eq("std_ovf",    32'(s_ov),     32'(c_err_en & m_s_ov));
        check_eq("std_unf",    32'(s_un),     32'(c_err_en & m_s_un));
        check_eq("fwft_count",  32'(f_count),  32'(fn));
        check_eq("fwft_empty",  32'(f_empty),  32'(!f_visible()));
        check_eq("fwft_full",   32'(f_full),   32'(fn == c_d));
        check_eq("fwft_afull",  32'(f_afull),  32'(fn >= c_af));
        check_eq("fwft_aempty", 32'(f_aempty), 32'(fn <= c_ae));
        check_eq("fwft_ovf",    32'(f_ov),     32'(c_err_en & m_f_ov));
        check_eq("fwft_unf",    32'(f_un),     32'(c_err_en & m_f_un));
        if (f_visible()) begin
            check_eq("fwft_dout", 32'(f_dout), 32'(fq[0].data));
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, update the models,
    // then sample the DUTs 1 time unit after the edge.
    task automatic step(input bit wr, input bit rd, input logic [c_w-1:0] d, input bit rst);
        bit    s_full0, s_empty0, f_full0, f_empty0;
        word_t tmp;
        wr_en    = wr;
        rd_en    = rd;
        din      = d;
        rst_sync = rst;
        s_full0  = (sq.size() == c_d);
        s_empty0 = (sq.size() == 0);
        f_full0  = (fq.size() == c_d);
        f_empty0 = !f_visible();
        @(posedge clk);
        edge_n++;
        if (rst) begin
            sq.delete();
            fq.delete();
            s_exp_dout = '0;
            last_pop   = 0;
            m_s_ov = 1'b0; m_s_un = 1'b0; m_f_ov = 1'b0; m_f_un = 1'b0;
        end else begin
            if (wr && s_full0)  m_s_ov = 1'b1;
            if (rd && s_empty0) m_s_un = 1'b1;
            if (wr && f_full0)  m_f_ov = 1'b1;
            if (rd && f_empty0) m_f_un = 1'b1;
            if (rd && !s_empty0) s_exp_dout = sq.pop_front();
            if (wr && !s_full0)  sq.push_back(d);
            if (rd && !f_empty0) begin
                tmp      = fq.pop_front();
                last_pop = edge_n;
            end
            if (wr && !f_full0) begin
                tmp.data  = d;
                tmp.wedge = edge_n;
                fq.push_back(tmp);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        int wbias;
        int rbias;
        rst_sync = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        edge_n   = 0;
        last_pop = 0;
        s_exp_dout = '0;
        m_s_ov = 1'b0; m_s_un = 1'b0; m_f_ov = 1'b0; m_f_un = 1'b0;

        // Reset then idle.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("rst_fwft_dout", 32'(f_dout), 32'h0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill 0x00..0x0F, one dropped write while full, then drain and
        // one read while empty.
        for (int i = 0; i < c_d; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        check_eq("fill_std_full", 32'(s_full), 32'h1);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        for (int i = 0; i < c_d; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("drain_std_last", 32'(s_dout), 32'h0F);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Single write into an empty FIFO; FWFT shows it two edges later.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check_eq("a5_fwft_empty_n", 32'(f_empty), 32'h1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("a5_fwft_dout", 32'(f_dout), 32'hA5);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("a5_fwft_count", 32'(f_count), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Full FIFO with simultaneous write and read.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < c_d; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'hBB, 1'b0);
        check_eq("full_rw_count", 32'(s_count), 32'd15);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Steady stream: one write and one read per cycle across many wraps.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);

        // Reset mid-burst at count 9, then a clean write/read.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        check_eq("midrst_count", 32'(s_count), 32'h0);
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("midrst_readback", 32'(s_dout), 32'h3C);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with shifting write/read bias and rare resets.
        wbias = 50;
        rbias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                wbias = int'($urandom_range(10, 90));
                rbias = int'($urandom_range(10, 90));
            end
            step($urandom_range(0, 99) < wbias,
                 $urandom_range(0, 99) < rbias,
                 8'($urandom),
                 $urandom_range(0, 499) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
